// File: rtl/mem_arbiter_rr.sv
// N-port memory arbiter: registered grant, round-robin or fixed priority,
// per-port response pulse and back-to-back grants with no idle cycle.
module mem_arbiter_rr #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic [DATA_WIDTH-1:0]            req_rdata,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_resp,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic                             busy,
  output logic [$clog2(NUM_PORTS)-1:0]     grant_idx
);

  localparam int GW = $clog2(NUM_PORTS);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state;

  logic [GW-1:0]         grant;
  logic [GW-1:0]         rr_ptr;
  logic [GW-1:0]         start;
  logic [GW-1:0]         win;
  logic [GW-1:0]         win_nxt;
  logic [NUM_PORTS-1:0]  req_any;
  logic [NUM_PORTS-1:0]  elig;
  logic                  found;
  logic                  in_busy;
  logic                  g_req;
  logic                  g_rd;
  logic                  g_wr;
  logic                  done;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;

  assign req_any = req_read | req_write;
  assign in_busy = (state == BUSY);

  assign g_req   = req_any[grant];
  assign g_wr    = req_write[grant];
  assign g_rd    = req_read[grant] & ~g_wr;
  assign g_addr  = req_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign g_wdata = req_wdata[grant*DATA_WIDTH +: DATA_WIDTH];
  assign done    = in_busy & mem_resp & g_req;

  assign start = (FIXED_PRIO != 0) ? '0 : rr_ptr;

  // The current grantee is excluded so it cannot win twice in a row.
  always_comb begin : arb
    int p;
    int q;
    logic [GW-1:0] idx;
    p     = 0;
    q     = 0;
    idx   = '0;
    found = 1'b0;
    win   = '0;
    elig  = req_any;
    if (in_busy) elig[grant] = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      p = int'(start) + k;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      idx = GW'(p);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    q = int'(win) + 1;
    win_nxt = (q == NUM_PORTS) ? '0 : GW'(q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state  <= BUSY;
            grant  <= win;
            rr_ptr <= win_nxt;
          end
        end
        BUSY: begin
          if (!g_req) begin
            state <= IDLE;
          end else if (mem_resp) begin
            if (found) begin
              grant  <= win;
              rr_ptr <= win_nxt;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign busy        = in_busy;
  assign grant_idx   = grant;
  assign mem_read    = in_busy & g_rd;
  assign mem_write   = in_busy & g_wr;
  assign mem_address = in_busy ? g_addr : '0;
  assign mem_wdata   = in_busy ? g_wdata : '0;
  assign req_resp    = done ?
    ({{(NUM_PORTS-1){1'b0}}, 1'b1} << grant) : '0;
  assign req_rdata   = reset ? '0 : mem_rdata;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: round-robin and fixed-priority instances,
// per-cycle behavioural model plus directed literal expectations.
module tb_mem_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N-1:0]    rd [2];
  logic [N-1:0]    wr [2];
  logic [N*AW-1:0] addr [2];
  logic [N*DW-1:0] wd [2];
  logic            mresp [2] = '{1'b0, 1'b0};
  logic [DW-1:0]   mrdata [2] = '{16'h0, 16'h0};
  logic [N-1:0]    resp [2];
  logic [DW-1:0]   rdata [2];
  logic            mread [2];
  logic            mwrite [2];
  logic [AW-1:0]   maddr [2];
  logic [DW-1:0]   mwdata [2];
  logic            busy [2];
  logic [GW-1:0]   gidx [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int   lat [2];
  int   cnt [2] = '{0, 0};
  logic stb_prev [2] = '{1'b0, 1'b0};
  int   rep [2][N];
  bit   autod [2][N];

  logic [N-1:0]  resp_q [2] = '{'0, '0};
  int            logv [2][64];
  int            logn [2] = '{0, 0};
  logic [DW-1:0] resp_rdata [2] = '{16'h0, 16'h0};
  int            rdc [2] = '{0, 0};
  int            wrc [2] = '{0, 0};
  int            busyc [2] = '{0, 0};

  bit m_busy [2] = '{1'b0, 1'b0};
  int m_grant [2] = '{0, 0};
  int m_last [2] = '{N-1, N-1};

  mem_arbiter_rr #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .FIXED_PRIO(0)
  ) u_rr (
    .clk(clk), .reset(rst),
    .req_read(rd[0]), .req_write(wr[0]),
    .req_addr(addr[0]), .req_wdata(wd[0]),
    .req_resp(resp[0]), .req_rdata(rdata[0]),
    .mem_read(mread[0]), .mem_write(mwrite[0]),
    .mem_address(maddr[0]), .mem_wdata(mwdata[0]),
    .mem_resp(mresp[0]), .mem_rdata(mrdata[0]),
    .busy(busy[0]), .grant_idx(gidx[0])
  );

  mem_arbiter_rr #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .FIXED_PRIO(1)
  ) u_fx (
    .clk(clk), .reset(rst),
    .req_read(rd[1]), .req_write(wr[1]),
    .req_addr(addr[1]), .req_wdata(wd[1]),
    .req_resp(resp[1]), .req_rdata(rdata[1]),
    .mem_read(mread[1]), .mem_write(mwrite[1]),
    .mem_address(maddr[1]), .mem_wdata(mwdata[1]),
    .mem_resp(mresp[1]), .mem_rdata(mrdata[1]),
    .busy(busy[1]), .grant_idx(gidx[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d cyc=%0d got=%0h want=%0h",
               nm, d, cyc, act, exp);
    end
  endtask

  // Winner among requesters r excluding port mask.
  function automatic int pick(input logic [N-1:0] r,
                              input int mask, input int last,
                              input bit fx);
    if (fx) begin
      for (int i = 0; i < N; i++)
        if (r[i] && i != mask) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last + k) % N;
        if (r[c] && c != mask) return c;
      end
    end
    return -1;
  endfunction

  task automatic cmp(input int d);
    logic [N-1:0] r;
    logic [N-1:0] eresp;
    bit eb;
    int g;
    int nx;
    r = rd[d] | wr[d];
    if (rst) begin
      chk("rst_busy", d, busy[d], 0);
      chk("rst_mem_read", d, mread[d], 0);
      chk("rst_mem_write", d, mwrite[d], 0);
      chk("rst_mem_addr", d, maddr[d], 0);
      chk("rst_req_resp", d, resp[d], 0);
      chk("rst_req_rdata", d, rdata[d], 0);
      chk("rst_grant", d, gidx[d], 0);
      m_busy[d] = 1'b0;
      m_last[d] = N - 1;
      resp_q[d] = '0;
      return;
    end
    eb = m_busy[d];
    g  = m_grant[d];
    eresp = (eb && mresp[d] && r[g]) ? (4'b0001 << g) : '0;
    chk("busy", d, busy[d], eb);
    if (eb) chk("grant", d, gidx[d], g);
    chk("mem_write", d, mwrite[d], eb & wr[d][g]);
    chk("mem_read", d, mread[d], eb & rd[d][g] & ~wr[d][g]);
    chk("mem_addr", d, maddr[d],
        eb ? addr[d][g*AW +: AW] : 16'h0);
    chk("mem_wdata", d, mwdata[d],
        eb ? wd[d][g*DW +: DW] : 16'h0);
    chk("req_resp", d, resp[d], eresp);
    chk("req_rdata", d, rdata[d], mrdata[d]);
    resp_q[d] = resp[d];
    if (resp[d] != '0) begin
      for (int i = 0; i < N; i++)
        if (resp[d][i] && logn[d] < 64) begin
          logv[d][logn[d]] = i;
          logn[d]++;
        end
      resp_rdata[d] = rdata[d];
    end
    rdc[d] += int'(mread[d]);
    wrc[d] += int'(mwrite[d]);
    busyc[d] += int'(busy[d]);
    if (!eb) begin
      nx = pick(r, -1, m_last[d], d == 1);
      if (nx >= 0) begin
        m_busy[d] = 1'b1;
        m_grant[d] = nx;
        m_last[d] = nx;
      end
    end else if (!r[g]) begin
      m_busy[d] = 1'b0;
    end else if (mresp[d]) begin
      nx = pick(r, g, m_last[d], d == 1);
      if (nx >= 0) begin
        m_grant[d] = nx;
        m_last[d] = nx;
      end else begin
        m_busy[d] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    cmp(0);
    cmp(1);
  end

  // Memory: responds after lat[d] strobe cycles; rdata = addr ^ 0xAEEF.
  task automatic mem_step(input int d);
    logic s;
    s = mread[d] | mwrite[d];
    if (rst) begin
      cnt[d] = 0;
      mresp[d] = 1'b0;
    end else begin
      if (mresp[d] || !stb_prev[d]) cnt[d] = 0;
      else cnt[d]++;
      mresp[d] = s && (cnt[d] >= lat[d] - 1);
    end
    stb_prev[d] = s;
    mrdata[d] = maddr[d] ^ 16'hAEEF;
  endtask

  always @(posedge clk) begin
    #2;
    mem_step(0);
    mem_step(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < N; p++)
        if (resp_q[d][p]) begin
          if (rep[d][p] > 0) rep[d][p]--;
          else if (autod[d][p]) begin
            rd[d][p] = 1'b0;
            wr[d][p] = 1'b0;
          end
        end
  endtask

  task automatic setreq(input int d, input int p,
                        input bit r, input bit w,
                        input logic [15:0] a,
                        input logic [15:0] dt);
    rd[d][p] = r;
    wr[d][p] = w;
    addr[d][p*AW +: AW] = a;
    wd[d][p*DW +: DW] = dt;
  endtask

  task automatic wait_resp(input int d, input int target,
                           input int budget, input string nm);
    int n;
    n = 0;
    while (logn[d] < target && n < budget) begin
      step();
      n++;
    end
    chk(nm, d, logn[d] >= target, 1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int b;
    int r0;
    int w0;
    int bc;
    int exp2 [5];
    int exp3 [3];
    exp2 = '{0, 1, 2, 3, 0};
    exp3 = '{1, 0, 3};
    for (int d = 0; d < 2; d++) begin
      rd[d] = '0;
      wr[d] = '0;
      addr[d] = '0;
      wd[d] = '0;
      lat[d] = 1;
      for (int p = 0; p < N; p++) begin
        rep[d][p] = 0;
        autod[d][p] = 1'b1;
      end
    end
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Single read, 3-cycle memory
    setreq(0, 0, 1, 0, 16'h1000, 16'h0);
    lat[0] = 3;
    b = logn[0];
    r0 = rdc[0];
    wait_resp(0, b + 1, 40, "t1_timeout");
    step();
    step();
    chk("t1_resp_count", 0, logn[0] - b, 1);
    chk("t1_port", 0, logv[0][b], 0);
    chk("t1_rdata", 0, resp_rdata[0], 16'hBEEF);
    chk("t1_read_cycles", 0, rdc[0] - r0, 3);

    // All four ports, 1-cycle memory, port 0 reissues once
    pulse_reset();
    for (int p = 0; p < N; p++)
      setreq(0, p, 1, 0, 16'h0100 + 16'(p * 2), 16'h0);
    rep[0][0] = 1;
    lat[0] = 1;
    b = logn[0];
    bc = busyc[0];
    wait_resp(0, b + 5, 60, "t2_timeout");
    for (int i = 0; i < 5; i++)
      chk("t2_order", 0, logv[0][b + i], exp2[i]);
    chk("t2_busy_cycles", 0, busyc[0] - bc, 5);
    step();
    step();

    // Fixed priority: 1 and 3, then 0 arrives during 1
    setreq(1, 1, 1, 0, 16'h0510, 16'h0);
    setreq(1, 3, 1, 0, 16'h0530, 16'h0);
    lat[1] = 3;
    b = logn[1];
    step();
    setreq(1, 0, 1, 0, 16'h0500, 16'h0);
    wait_resp(1, b + 3, 60, "t3_timeout");
    for (int i = 0; i < 3; i++)
      chk("t3_order", 1, logv[1][b + i], exp3[i]);
    step();
    step();

    // Read+write on one port, held one cycle past resp
    autod[0][2] = 1'b0;
    setreq(0, 2, 1, 1, 16'h2002, 16'h00AA);
    lat[0] = 2;
    b = logn[0];
    r0 = rdc[0];
    w0 = wrc[0];
    wait_resp(0, b + 1, 40, "t4_timeout");
    step();
    setreq(0, 2, 0, 0, 16'h0, 16'h0);
    autod[0][2] = 1'b1;
    step();
    step();
    chk("t4_resp_count", 0, logn[0] - b, 1);
    chk("t4_port", 0, logv[0][b], 2);
    chk("t4_read_cycles", 0, rdc[0] - r0, 0);
    chk("t4_write_cycles", 0, wrc[0] - w0, 2);

    // Reset in the middle of port 1's transaction
    pulse_reset();
    setreq(0, 0, 1, 0, 16'h3000, 16'h0);
    lat[0] = 1;
    wait_resp(0, logn[0] + 1, 40, "t5a_timeout");
    setreq(0, 1, 1, 0, 16'h3100, 16'h0);
    lat[0] = 20;
    repeat (3) step();
    #2;
    chk("t5_pre_busy", 0, busy[0], 1);
    chk("t5_pre_grant", 0, gidx[0], 1);
    rst = 1'b1;
    #1;
    chk("t5_async_busy", 0, busy[0], 0);
    chk("t5_async_read", 0, mread[0], 0);
    setreq(0, 3, 1, 0, 16'h3300, 16'h0);
    step();
    step();
    rst = 1'b0;
    lat[0] = 2;
    b = logn[0];
    wait_resp(0, b + 2, 60, "t5_timeout");
    chk("t5_first", 0, logv[0][b], 1);
    chk("t5_second", 0, logv[0][b + 1], 3);
    step();
    step();

    // Granted port abandons its request before mem_resp
    pulse_reset();
    setreq(0, 0, 1, 0, 16'h4000, 16'h0);
    setreq(0, 2, 1, 0, 16'h4200, 16'h0);
    lat[0] = 10;
    b = logn[0];
    step();
    step();
    setreq(0, 0, 0, 0, 16'h0, 16'h0);
    lat[0] = 2;
    #1;
    chk("t6_strobe_fall", 0, mread[0], 0);
    chk("t6_busy_hold", 0, busy[0], 1);
    wait_resp(0, b + 1, 40, "t6_timeout");
    step();
    chk("t6_resp_count", 0, logn[0] - b, 1);
    chk("t6_port", 0, logv[0][b], 2);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised N-port memory arbiter that multiplexes read/write requests from several pipeline clients (instruction fetch, data memory stage, future prefetch/DMA ports) onto a single memory/cache interface. It replaces the two-state fetch/mem ping-pong with:
- a registered grant;
- selectable round-robin or fixed-priority arbitration;
- a per-port response handshake;
- back-to-back grants without bubble cycles.

## Interface
- NUM_PORTS, 2, number of requesting ports (2..8); port 0 is highest priority in fixed mode
- ADDR_WIDTH, 16, address width (lc3b_word width by default)
- DATA_WIDTH, 16, write/read data width
- FIXED_PRIO, 0, 0 = round-robin arbitration, 1 = fixed priority (lowest index wins)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_read  in  NUM_PORTS  per-port read request, level, held until that port's req_resp
- req_write  in  NUM_PORTS  per-port write request, level, held until req_resp
- req_addr  in  NUM_PORTS*ADDR_WIDTH  flattened per-port address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_PORTS*DATA_WIDTH  flattened per-port write data
- req_resp  out  NUM_PORTS  one-cycle completion pulse to the granted port
- req_rdata  out  DATA_WIDTH  read data, broadcast copy of mem_rdata
- mem_read  out  1  read strobe to memory
- mem_write  out  1  write strobe to memory
- mem_address  out  ADDR_WIDTH  address to memory
- mem_wdata  out  DATA_WIDTH  write data to memory
- mem_resp  in  1  memory completion, one cycle, valid only while a strobe is asserted
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_resp
- busy  out  1  high while a transaction is in flight (state BUSY)
- grant_idx  out  $clog2(NUM_PORTS)  currently granted port, meaningful only when busy

## Operation
- A port is requesting when req_read[i] | req_write[i].
- If both bits are set on one port, the write wins and mem_read is forced 0 for that transaction.

State machine:
- IDLE:
  - mem_read = mem_write = 0, mem_address = 0, mem_wdata = 0, req_resp = 0.
  - If any port is requesting, latch the winner into the grant register and go to BUSY at the next edge.
- BUSY:
  - mem_read/mem_write/mem_address/mem_wdata are driven combinationally from the granted port's inputs.
  - On mem_resp: req_resp[grant] = 1 in the same cycle, then re-arbitrate.
    - The current grantee is masked out of this re-arbitration.
    - If another port is requesting, load the new grant and stay in BUSY (back-to-back, no idle cycle).
    - Otherwise go to IDLE.
  - If the granted port drops both request bits before mem_resp (protocol violation), go to IDLE at the next edge with no resp pulse. Strobes follow the port's inputs and drop in that same cycle.

Arbitration:
- Round-robin: rr_ptr is the index after the last granted port.
  - The search starts at rr_ptr and wraps modulo NUM_PORTS.
  - rr_ptr updates only when a grant is loaded.
- Fixed: lowest-index requesting port wins; rr_ptr is ignored.

Reset: state = IDLE, grant = 0, rr_ptr = 0. All outputs read 0 while reset is high. A mid-transaction reset abandons the transaction and produces no req_resp.

## Timing
- Request to memory strobe: 1 cycle. A request seen in IDLE at edge k gives a strobe in cycle k+1.
- Memory latency is arbitrary. req_resp coincides with mem_resp; req_rdata is valid in that cycle.
- Back-to-back: the next port's strobe appears in the cycle after the mem_resp cycle. There is no gap cycle between transactions.
- A request asserted on the same cycle as another port's mem_resp is eligible in that cycle's re-arbitration.
- A port never receives two consecutive grants while another port is requesting. In round-robin mode, any single port waits at most NUM_PORTS-1 transactions.
- Requester contract: hold address, data and request bits stable from assertion until the req_resp cycle. Deassert in the cycle after req_resp, or issue a new request then.

## Test plan
- NUM_PORTS=2, FIXED_PRIO=0; port 0 reads 0x1000 alone, mem_resp after 3 cycles with 0xBEEF -> mem_read high for exactly 3 cycles at 0x1000; req_resp=2'b01 once; req_rdata=0xBEEF; busy falls the next cycle.
- NUM_PORTS=4, round-robin; all four ports hold read requests, memory responds in 1 cycle -> grants 0,1,2,3,0 with no idle cycle between them; each req_resp pulses once per grant.
- NUM_PORTS=4, FIXED_PRIO=1; ports 1 and 3 requesting, port 0 raises a request during port 1's transaction -> order 1,0,3.
- Single port 2 (NUM_PORTS=3) requests write 0x00AA to 0x2002 with both read and write set, then holds the request one cycle past resp -> mem_write=1 and mem_read=0 during the transaction; after resp the arbiter goes through IDLE before regranting, because the grantee is masked.
- Reset asserted mid-transaction (BUSY, grant=1, no mem_resp yet) -> mem_read/mem_write/busy go to 0 asynchronously with no req_resp; after release, the next round-robin grant starts from port 0.
- Granted port drops its request before mem_resp -> strobe falls in the same cycle, state is IDLE at the next edge, req_resp stays 0, and the other pending port is granted next.
